fifo_scx_wc: RTL and testbench
==============================

# fifo_scx_wc

Single-clock FIFO with power-of-two width conversion between write and read ports, programmable almost-full/almost-empty thresholds and live word counts. It is the single-clock successor to the dual-clock width-converting FIFO and is used where producer and consumer share one clock domain. Depth, widths, ratio direction and thresholds are set at elaboration.

## Interface
- module_widthw, 2: write word width in bits.
- module_widthr, 4: read word width in bits.
  - Ratio module_widthr/module_widthw or its inverse is 2^k, with k in 0..4.
- module_numwordsw, 16: depth in write words.
  - module_numwordsw * module_widthw must be a multiple of module_widthr.
  - Read depth is module_numwordsr = module_numwordsw * module_widthw / module_widthr.
- module_widthuw, 5: write count width; equals clog2(module_numwordsw)+1.
- module_widthur, 4: read count width; equals clog2(module_numwordsr)+1.
- module_amfull_flag, 1: AlmostFull threshold, in write words of remaining space.
- module_amempty_flag, 1: AlmostEmpty threshold, in read words.
- Clock  in  1: single clock; all logic is rising-edge.
- Reset  in  1: synchronous, active-high.
- Data  in  module_widthw: write data.
- WrEn  in  1: write request.
- RdEn  in  1: read request.
- Q  out  module_widthr: read data, registered.
- Full  out  1: no room for one write word.
- Empty  out  1: less than one read word stored.
- AlmostFull  out  1: WrCount >= module_numwordsw - module_amfull_flag.
- AlmostEmpty  out  1: RdCount <= module_amempty_flag.
- WrCount  out  module_widthuw: stored data in whole write words.
- RdCount  out  module_widthur: stored data in whole read words.
- Overflow, Underflow  out  1 each: present only with FIFO_SCX_ERRFLAG_EN.

## Operation
- Unit U = min(widthw, widthr). W = widthw/U units per write; R = widthr/U units per read. Capacity D = numwordsw*W units.
- Internal count cnt is in units, range 0..D.
  - WrCount = cnt/W, RdCount = cnt/R, both truncating.
- A write is accepted iff WrEn && !Full. A read is accepted iff RdEn && !Empty. Rejected requests change no state.
- Full = (D - cnt) < W. Empty = cnt < R.
- Lane order is little-endian.
  - Narrow write, wide read: the first written word occupies Q[widthw-1:0].
  - Wide write, narrow read: Data[widthr-1:0] is read first.
- A partially filled wide entry is never readable: Empty stays 1 until R units are present.
- Storage is wide-word-organised with a lane pointer on the narrow side.
- Pointers wrap modulo the entry count; the lane pointer wraps modulo the ratio and carries into the entry pointer.
- Simultaneous accepted read and write: cnt += W - R. Both pointers advance.
- Read-before-write is not needed: a read never targets the entry being written, because of the Empty rule.
- Reset has priority over WrEn/RdEn in the same cycle and clears all pointers, lane indices and counts. Stored data is discarded and Q reads 0.

## Timing
- Reset values: Q=0, Empty=1, AlmostEmpty=1, Full=0, AlmostFull=(module_amfull_flag >= module_numwordsw), WrCount=0, RdCount=0, Overflow=0, Underflow=0.
- All flags and counts are registered and reflect state after the last edge; they update on the same edge as the accepted operation.
- Write-to-Empty latency: Empty falls on the edge that completes the R-th unit. The word can be read in the next cycle.
- Read latency 1: Q updates on the edge that accepts RdEn and holds until the next accepted read.
- Full with RdEn && WrEn asserted: only the read is accepted; Full deasserts on that edge if space >= W.
- Empty with RdEn && WrEn asserted: only the write is accepted.

## Configuration
- FIFO_SCX_ERRFLAG_EN defined: adds sticky Overflow and Underflow outputs.
  - Overflow sets on WrEn && Full; Underflow sets on RdEn && Empty.
  - Both clear only on Reset and are visible on the edge after the offending cycle.
- FIFO_SCX_ERRFLAG_EN undefined: both ports and their logic are absent. Rejected requests are silently ignored.

## Structure
- Package fifo_scx_pkg holds:
  - clog2 function;
  - ratio and lane-count constants derived from the widths;
  - lane-index and unit-count typedefs.
- Sub-module fifo_scx_ram: simple dual-port synchronous RAM, one clock, wide-word entries.
  - Per-lane write enables.
  - Registered read port feeding Q directly, or through a lane mux for narrow reads.
- Pointer, lane and count logic lives in fifo_scx_wc.

## Test plan
- Reset, then idle: Empty=1, AlmostEmpty=1, Full=0, WrCount=0, Q=0.
- widthw=2, widthr=4: write 2'h1 then 2'h2, then read. Empty falls after the 2nd write; Q=4'h9; Empty returns to 1.
- widthw=4, widthr=2: write 4'hC, then read twice. Q=2'h0 then 2'h3; RdCount goes 2→1→0.
- Fill 16 writes (depth 16): Full=1, AlmostFull rises at WrCount=15. A 17th WrEn is ignored; with FIFO_SCX_ERRFLAG_EN, Overflow=1.
- At Full, apply RdEn and WrEn in the same cycle: only the read is accepted, and Full=0 on the next cycle. Then run 100 cycles of simultaneous read/write with pointer wrap: data order is preserved.
- Assert Reset mid-burst with WrEn=RdEn=1: all outputs return to their reset values on the next edge, and no write is accepted in that cycle.

Source files
------------

// File: rtl/fifo_scx_pkg.sv
// Shared constants, helpers and typedefs for the single-clock width-converting FIFO.
// Lane indices cover ratios up to 16; unit counts cover capacities up to 65535 units.
package fifo_scx_pkg;

    localparam int DEF_WIDTHW   = 2;
    localparam int DEF_WIDTHR   = 4;
    localparam int MAX_LANES    = 16;

    typedef logic [3:0]  lane_t;
    typedef logic [15:0] ucnt_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unit_width(input int ww, input int wr);
        return (ww < wr) ? ww : wr;
    endfunction

    function automatic int lanes_of(input int ww, input int wr);
        return (ww > wr) ? (ww / wr) : (wr / ww);
    endfunction

    localparam int DEF_UNIT_W = unit_width(DEF_WIDTHW, DEF_WIDTHR);
    localparam int DEF_LANES  = lanes_of(DEF_WIDTHW, DEF_WIDTHR);

endpackage

// File: rtl/fifo_scx_wc_if.sv
// Handshake/data bundle of fifo_scx_wc; error flag signals exist only with FIFO_SCX_ERRFLAG_EN.
interface fifo_scx_wc_if #(
    parameter int WIDTHW  = 2,
    parameter int WIDTHR  = 4,
    parameter int WIDTHUW = 5,
    parameter int WIDTHUR = 4
);
    logic [WIDTHW-1:0]  Data;
    logic               WrEn;
    logic               RdEn;
    logic [WIDTHR-1:0]  Q;
    logic               Full;
    logic               Empty;
    logic               AlmostFull;
    logic               AlmostEmpty;
    logic [WIDTHUW-1:0] WrCount;
    logic [WIDTHUR-1:0] RdCount;
`ifdef FIFO_SCX_ERRFLAG_EN
    logic               Overflow;
    logic               Underflow;

    modport master (output Data, WrEn, RdEn,
                    input  Q, Full, Empty, AlmostFull, AlmostEmpty, WrCount, RdCount,
                           Overflow, Underflow);
    modport slave  (input  Data, WrEn, RdEn,
                    output Q, Full, Empty, AlmostFull, AlmostEmpty, WrCount, RdCount,
                           Overflow, Underflow);
`else
    modport master (output Data, WrEn, RdEn,
                    input  Q, Full, Empty, AlmostFull, AlmostEmpty, WrCount, RdCount);
    modport slave  (input  Data, WrEn, RdEn,
                    output Q, Full, Empty, AlmostFull, AlmostEmpty, WrCount, RdCount);
`endif
endinterface

// File: rtl/fifo_scx_ram.sv
// Simple dual-port RAM with wide-word entries split into per-lane memories,
// registered read port and a lane mux selecting the narrow read word.
module fifo_scx_ram
    import fifo_scx_pkg::*;
#(
    parameter int UNIT_W   = 2,
    parameter int LANES    = 2,
    parameter int ENTRIES  = 8,
    parameter int AW       = 3,
    parameter int RD_W     = 4,
    parameter int RD_LANES = 1
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic [LANES-1:0]        we_i,
    input  logic [AW-1:0]           waddr_i,
    input  logic [LANES*UNIT_W-1:0] wdata_i,
    input  logic                    re_i,
    input  logic [AW-1:0]           raddr_i,
    input  lane_t                   rlane_i,
    output logic [RD_W-1:0]         rdata_o
);
    logic [LANES*UNIT_W-1:0] entry_w;
    logic [RD_W-1:0]         rd_lane_w [RD_LANES];
    lane_t                   rlane_q;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [UNIT_W-1:0] mem [ENTRIES];
        logic [UNIT_W-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (we_i[gi]) mem[waddr_i] <= wdata_i[gi*UNIT_W +: UNIT_W];
            if (srst)      rd_q <= '0;
            else if (re_i) rd_q <= mem[raddr_i];
        end

        assign entry_w[gi*UNIT_W +: UNIT_W] = rd_q;
    end

    for (genvar gi = 0; gi < RD_LANES; gi++) begin : g_rd
        assign rd_lane_w[gi] = entry_w[gi*RD_W +: RD_W];
    end

    // The lane index is captured with the read so Q holds between accepted reads.
    always_ff @(posedge clk) begin
        if (srst)      rlane_q <= '0;
        else if (re_i) rlane_q <= rlane_i;
    end

    always_comb begin
        rdata_o = rd_lane_w[0];
        for (int i = 0; i < RD_LANES; i++) begin
            if (rlane_q == lane_t'(i)) rdata_o = rd_lane_w[i];
        end
    end

endmodule

// File: rtl/fifo_scx_wc.sv
// Single-clock FIFO with power-of-two width conversion, thresholds and live counts.
// Define FIFO_SCX_ERRFLAG_EN to add sticky Overflow/Underflow outputs.
module fifo_scx_wc
    import fifo_scx_pkg::*;
#(
    parameter int module_widthw       = 2,
    parameter int module_widthr       = 4,
    parameter int module_numwordsw    = 16,
    parameter int module_widthuw      = 5,
    parameter int module_widthur      = 4,
    parameter int module_amfull_flag  = 1,
    parameter int module_amempty_flag = 1
) (
    input  logic          Clock,
    input  logic          Reset,
    fifo_scx_wc_if.slave  bus
);
    localparam int U     = unit_width(module_widthw, module_widthr);
    localparam int W     = module_widthw / U;
    localparam int R     = module_widthr / U;
    localparam int LANES = lanes_of(module_widthw, module_widthr);
    localparam int D     = module_numwordsw * W;
    localparam int NE    = D / LANES;
    localparam int AW    = (clog2(NE) > 0) ? clog2(NE) : 1;
    localparam int WL    = LANES / W;
    localparam int RL    = LANES / R;
    localparam int WSH   = clog2(W);
    localparam int RSH   = clog2(R);

    logic [AW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    lane_t                     wr_lane_q, wr_lane_d, rd_lane_q, rd_lane_d;
    ucnt_t                     cnt_q, cnt_d;
    logic                      full_q, full_d, empty_q, empty_d;
    logic                      afull_q, afull_d, aempty_q, aempty_d;
    logic [module_widthuw-1:0] wr_count_q, wr_count_d;
    logic [module_widthur-1:0] rd_count_q, rd_count_d;
    logic                      wr_acc, rd_acc;
    logic [LANES-1:0]          we_lane;
    logic [LANES*U-1:0]        wdata;

    assign wr_acc = bus.WrEn && !full_q;
    assign rd_acc = bus.RdEn && !empty_q;
    assign wdata  = {WL{bus.Data}};

    // Narrow writes hit one lane group; a wide write (WL == 1) enables every lane.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_we
        assign we_lane[gi] = wr_acc && (wr_lane_q == lane_t'(gi / W));
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        wr_lane_d = wr_lane_q;
        rd_ptr_d  = rd_ptr_q;
        rd_lane_d = rd_lane_q;
        if (wr_acc) begin
            if (wr_lane_q == lane_t'(WL - 1)) begin
                wr_lane_d = '0;
                wr_ptr_d  = (wr_ptr_q == AW'(NE - 1)) ? '0 : wr_ptr_q + AW'(1);
            end else begin
                wr_lane_d = wr_lane_q + lane_t'(1);
            end
        end
        if (rd_acc) begin
            if (rd_lane_q == lane_t'(RL - 1)) begin
                rd_lane_d = '0;
                rd_ptr_d  = (rd_ptr_q == AW'(NE - 1)) ? '0 : rd_ptr_q + AW'(1);
            end else begin
                rd_lane_d = rd_lane_q + lane_t'(1);
            end
        end
        cnt_d      = cnt_q + (wr_acc ? ucnt_t'(W) : ucnt_t'(0)) - (rd_acc ? ucnt_t'(R) : ucnt_t'(0));
        wr_count_d = module_widthuw'(cnt_d >> WSH);
        rd_count_d = module_widthur'(cnt_d >> RSH);
        full_d     = (ucnt_t'(D) - cnt_d) < ucnt_t'(W);
        empty_d    = cnt_d < ucnt_t'(R);
        afull_d    = int'(wr_count_d) >= (module_numwordsw - module_amfull_flag);
        aempty_d   = int'(rd_count_d) <= module_amempty_flag;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr_q   <= '0;
            wr_lane_q  <= '0;
            rd_ptr_q   <= '0;
            rd_lane_q  <= '0;
            cnt_q      <= '0;
            wr_count_q <= '0;
            rd_count_q <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= (module_amfull_flag >= module_numwordsw);
            aempty_q   <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            wr_lane_q  <= wr_lane_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_lane_q  <= rd_lane_d;
            cnt_q      <= cnt_d;
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            afull_q    <= afull_d;
            aempty_q   <= aempty_d;
        end
    end

    fifo_scx_ram #(
        .UNIT_W   (U),
        .LANES    (LANES),
        .ENTRIES  (NE),
        .AW       (AW),
        .RD_W     (module_widthr),
        .RD_LANES (RL)
    ) u_ram (
        .clk     (Clock),
        .srst    (Reset),
        .we_i    (we_lane),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q),
        .rlane_i (rd_lane_q),
        .rdata_o (bus.Q)
    );

    assign bus.Full        = full_q;
    assign bus.Empty       = empty_q;
    assign bus.AlmostFull  = afull_q;
    assign bus.AlmostEmpty = aempty_q;
    assign bus.WrCount     = wr_count_q;
    assign bus.RdCount     = rd_count_q;

`ifdef FIFO_SCX_ERRFLAG_EN
    logic ovf_q, udf_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (bus.WrEn && full_q);
            udf_q <= udf_q | (bus.RdEn && empty_q);
        end
    end

    assign bus.Overflow  = ovf_q;
    assign bus.Underflow = udf_q;
`endif

endmodule

// File: tb/tb_fifo_scx_wc.sv
// Directed bench for fifo_scx_wc: a narrow-to-wide instance (2->4) and a wide-to-narrow one (4->2).
module tb_fifo_scx_wc;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fifo_scx_wc_if #(.WIDTHW(2), .WIDTHR(4), .WIDTHUW(5), .WIDTHUR(4)) bus_a ();
    fifo_scx_wc_if #(.WIDTHW(4), .WIDTHR(2), .WIDTHUW(5), .WIDTHUR(6)) bus_b ();

    fifo_scx_wc #(
        .module_widthw(2), .module_widthr(4), .module_numwordsw(16),
        .module_widthuw(5), .module_widthur(4),
        .module_amfull_flag(1), .module_amempty_flag(1)
    ) u_a (.Clock(clk), .Reset(rst_a), .bus(bus_a));

    fifo_scx_wc #(
        .module_widthw(4), .module_widthr(2), .module_numwordsw(16),
        .module_widthuw(5), .module_widthur(6),
        .module_amfull_flag(1), .module_amempty_flag(1)
    ) u_b (.Clock(clk), .Reset(rst_b), .bus(bus_b));

    typedef struct {
        logic       wr;
        logic       rd;
        logic [1:0] d;
        logic [3:0] q;
        logic       e;
        logic [4:0] wc;
        logic [3:0] rc;
    } vec_t;

    vec_t       vt [10];
    logic [1:0] mq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected flags of instance A derived from its stored write-word count.
    task automatic chk_a(input string tag, input logic [3:0] eq, input int cnt);
        chk({tag, " Q"},           32'(bus_a.Q),           32'(eq));
        chk({tag, " Empty"},       32'(bus_a.Empty),       32'(cnt < 2));
        chk({tag, " Full"},        32'(bus_a.Full),        32'(cnt == 16));
        chk({tag, " WrCount"},     32'(bus_a.WrCount),     32'(cnt));
        chk({tag, " RdCount"},     32'(bus_a.RdCount),     32'(cnt / 2));
        chk({tag, " AlmostFull"},  32'(bus_a.AlmostFull),  32'(cnt >= 15));
        chk({tag, " AlmostEmpty"}, 32'(bus_a.AlmostEmpty), 32'((cnt / 2) <= 1));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_q;
        int         mcnt;
        bit         wr_ok, rd_ok;

        vt[0] = '{1'b1, 1'b0, 2'h1, 4'h0, 1'b1, 5'd1, 4'd0};
        vt[1] = '{1'b1, 1'b0, 2'h2, 4'h0, 1'b0, 5'd2, 4'd1};
        vt[2] = '{1'b0, 1'b1, 2'h0, 4'h9, 1'b1, 5'd0, 4'd0};
        vt[3] = '{1'b0, 1'b0, 2'h0, 4'h9, 1'b1, 5'd0, 4'd0};
        vt[4] = '{1'b0, 1'b1, 2'h0, 4'h9, 1'b1, 5'd0, 4'd0};
        vt[5] = '{1'b1, 1'b0, 2'h3, 4'h9, 1'b1, 5'd1, 4'd0};
        vt[6] = '{1'b1, 1'b0, 2'h0, 4'h9, 1'b0, 5'd2, 4'd1};
        vt[7] = '{1'b1, 1'b1, 2'h2, 4'h3, 1'b1, 5'd1, 4'd0};
        vt[8] = '{1'b1, 1'b1, 2'h1, 4'h3, 1'b0, 5'd2, 4'd1};
        vt[9] = '{1'b0, 1'b1, 2'h0, 4'h6, 1'b1, 5'd0, 4'd0};

        bus_a.Data = '0; bus_a.WrEn = 1'b0; bus_a.RdEn = 1'b0;
        bus_b.Data = '0; bus_b.WrEn = 1'b0; bus_b.RdEn = 1'b0;
        step();
        rst_a = 1'b0;
        rst_b = 1'b0;
        step();
        chk_a("reset", 4'h0, 0);

        for (int i = 0; i < 10; i++) begin
            bus_a.WrEn = vt[i].wr;
            bus_a.RdEn = vt[i].rd;
            bus_a.Data = vt[i].d;
            step();
            $display("vec %0d wr=%0b rd=%0b d=%0h -> Q=%0h Empty=%0b WrCount=%0d RdCount=%0d",
                     i, vt[i].wr, vt[i].rd, vt[i].d, bus_a.Q, bus_a.Empty, bus_a.WrCount, bus_a.RdCount);
            chk($sformatf("vec%0d Q", i),       32'(bus_a.Q),       32'(vt[i].q));
            chk($sformatf("vec%0d Empty", i),   32'(bus_a.Empty),   32'(vt[i].e));
            chk($sformatf("vec%0d Full", i),    32'(bus_a.Full),    32'(0));
            chk($sformatf("vec%0d WrCount", i), 32'(bus_a.WrCount), 32'(vt[i].wc));
            chk($sformatf("vec%0d RdCount", i), 32'(bus_a.RdCount), 32'(vt[i].rc));
        end
        bus_a.WrEn = 1'b0;
        bus_a.RdEn = 1'b0;
`ifdef FIFO_SCX_ERRFLAG_EN
        chk("underflow sticky", 32'(bus_a.Underflow), 32'(1));
        chk("overflow idle",    32'(bus_a.Overflow),  32'(0));
`endif

        // Fill to capacity, then one extra write that must be ignored.
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        chk_a("refill reset", 4'h0, 0);
        mq.delete();
        for (int k = 1; k <= 16; k++) begin
            bus_a.WrEn = 1'b1;
            bus_a.Data = 2'(k - 1);
            mq.push_back(2'(k - 1));
            step();
            $display("fill %0d -> WrCount=%0d Full=%0b AlmostFull=%0b", k, bus_a.WrCount, bus_a.Full, bus_a.AlmostFull);
            chk_a($sformatf("fill%0d", k), 4'h0, k);
        end
        bus_a.Data = 2'h3;
        step();
        $display("write at full -> WrCount=%0d Full=%0b", bus_a.WrCount, bus_a.Full);
        chk_a("write at full", 4'h0, 16);
`ifdef FIFO_SCX_ERRFLAG_EN
        chk("overflow sticky", 32'(bus_a.Overflow), 32'(1));
`endif

        // Read and write together at Full: only the read is taken.
        bus_a.RdEn = 1'b1;
        bus_a.Data = 2'h2;
        exp_q = {mq[1], mq[0]};
        void'(mq.pop_front());
        void'(mq.pop_front());
        step();
        $display("rd+wr at full -> Q=%0h WrCount=%0d Full=%0b", bus_a.Q, bus_a.WrCount, bus_a.Full);
        chk_a("rdwr at full", exp_q, 14);
        chk("rdwr at full Q value", 32'(bus_a.Q), 32'(4'h4));

        // Streaming with pointer wrap against a queue model.
        for (int c = 0; c < 100; c++) begin
            mcnt  = mq.size();
            wr_ok = (mcnt < 16);
            rd_ok = (mcnt >= 2);
            bus_a.WrEn = 1'b1;
            bus_a.RdEn = 1'b1;
            bus_a.Data = 2'((c * 3 + 1) ^ (c >> 2));
            if (rd_ok) begin
                exp_q = {mq[1], mq[0]};
                void'(mq.pop_front());
                void'(mq.pop_front());
            end
            if (wr_ok) mq.push_back(bus_a.Data);
            step();
            $display("stream %0d d=%0h -> Q=%0h WrCount=%0d", c, bus_a.Data, bus_a.Q, bus_a.WrCount);
            chk_a($sformatf("stream%0d", c), exp_q, mq.size());
        end

        // Reset during an active burst wins over both requests.
        rst_a = 1'b1;
        step();
        $display("reset mid-burst -> Q=%0h WrCount=%0d Empty=%0b", bus_a.Q, bus_a.WrCount, bus_a.Empty);
        chk_a("reset burst", 4'h0, 0);
`ifdef FIFO_SCX_ERRFLAG_EN
        chk("reset Overflow",  32'(bus_a.Overflow),  32'(0));
        chk("reset Underflow", 32'(bus_a.Underflow), 32'(0));
`endif
        rst_a = 1'b0;
        bus_a.WrEn = 1'b0;
        bus_a.RdEn = 1'b0;
        step();
        chk_a("after reset idle", 4'h0, 0);

        // Wide write, narrow read: low half comes out first.
        bus_b.WrEn = 1'b1;
        bus_b.Data = 4'hC;
        step();
        bus_b.Data = 4'h6;
        step();
        bus_b.Data = 4'h9;
        step();
        bus_b.WrEn = 1'b0;
        $display("B after 3 writes -> WrCount=%0d RdCount=%0d Empty=%0b", bus_b.WrCount, bus_b.RdCount, bus_b.Empty);
        chk("B WrCount", 32'(bus_b.WrCount), 32'(3));
        chk("B RdCount", 32'(bus_b.RdCount), 32'(6));
        chk("B Empty",   32'(bus_b.Empty),   32'(0));
        begin
            logic [1:0] b_exp [6];
            b_exp[0] = 2'h0; b_exp[1] = 2'h3; b_exp[2] = 2'h2;
            b_exp[3] = 2'h1; b_exp[4] = 2'h1; b_exp[5] = 2'h2;
            bus_b.RdEn = 1'b1;
            for (int i = 0; i < 6; i++) begin
                step();
                $display("B read %0d -> Q=%0h RdCount=%0d", i, bus_b.Q, bus_b.RdCount);
                chk($sformatf("B read%0d Q", i),       32'(bus_b.Q),       32'(b_exp[i]));
                chk($sformatf("B read%0d RdCount", i), 32'(bus_b.RdCount), 32'(5 - i));
            end
            bus_b.RdEn = 1'b0;
        end
        chk("B Empty end",       32'(bus_b.Empty),       32'(1));
        chk("B AlmostEmpty end", 32'(bus_b.AlmostEmpty), 32'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
